encoder_seq: RTL and testbench

ENCODER_SEQ -- requirements
Module: encoder_seq

---
 rtl/encoder_seq.sv | 92 +++++++++
 tb/tb_encoder_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/encoder_seq.sv
// Sequential priority encoder: captures a 4-bit request vector, then emits
// the index of each set bit one beat at a time under a valid/ready handshake.
module encoder_seq #(
    parameter bit PRIORITY_HIGH = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] din,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] y,
    output logic       last,
    output logic       zero
);

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_pending;
    logic [3:0] w_pending_next;
    logic       r_zflag;
    logic       w_zflag_next;
    logic [1:0] w_sel_idx;
    logic       w_at_most_one;

    // Scan order makes the winning bit the last one assigned.
    always_comb begin
        w_sel_idx = 2'd0;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < 4; i++) begin
                if (r_pending[i]) w_sel_idx = 2'(i);
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (r_pending[i]) w_sel_idx = 2'(i);
            end
        end
    end

    assign w_at_most_one = ((r_pending & (r_pending - 4'd1)) == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= 4'd0;
            r_zflag   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_zflag   <= w_zflag_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_zflag_next   = r_zflag;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_pending_next = din;
                    w_zflag_next   = (din == 4'd0);
                    w_state_next   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    w_pending_next = r_pending & ~(4'b0001 << w_sel_idx);
                    if (w_at_most_one) begin
                        w_state_next = ST_IDLE;
                        w_zflag_next = 1'b0;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs depend on registered state only; beat fields are forced to 0 when idle.
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_EMIT);
    assign y         = out_valid ? w_sel_idx : 2'd0;
    assign last      = out_valid & w_at_most_one;
    assign zero      = out_valid & r_zflag;

endmodule

// File: tb/tb_encoder_seq.sv
// Scoreboard bench for encoder_seq: both priority orders share one stimulus
// stream; a reference model queues expected beats, a monitor checks them.
module tb_encoder_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] din = 4'd0;
    logic       out_ready = 1'b1;

    logic       lo_in_ready, lo_out_valid, lo_last, lo_zero;
    logic [1:0] lo_y;
    logic       hi_in_ready, hi_out_valid, hi_last, hi_zero;
    logic [1:0] hi_y;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    int beats_left = 0;

    // Beat packing: {y[1:0], last, zero}
    logic [3:0] q_lo[$];
    logic [3:0] q_hi[$];

    always #5 clk = ~clk;

    encoder_seq #(.PRIORITY_HIGH(1'b0)) u_lo (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .in_ready(lo_in_ready), .out_valid(lo_out_valid), .out_ready(out_ready),
        .y(lo_y), .last(lo_last), .zero(lo_zero)
    );

    encoder_seq #(.PRIORITY_HIGH(1'b1)) u_hi (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .in_ready(hi_in_ready), .out_valid(hi_out_valid), .out_ready(out_ready),
        .y(hi_y), .last(hi_last), .zero(hi_zero)
    );

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: list the set-bit indices in the requested order.
    task automatic push_beats(input logic [3:0] v);
        int idx[$];
        int n;
        for (int i = 0; i < 4; i++) if (v[i]) idx.push_back(i);
        n = idx.size();
        if (n == 0) begin
            q_lo.push_back(4'b0011);
            q_hi.push_back(4'b0011);
        end else begin
            for (int k = 0; k < n; k++) begin
                q_lo.push_back({2'(idx[k]), (k == n - 1), 1'b0});
                q_hi.push_back({2'(idx[n - 1 - k]), (k == n - 1), 1'b0});
            end
        end
        beats_left = (n == 0) ? 1 : n;
    endtask

    // Model of acceptance/handshakes, sampled at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                q_lo.delete();
                q_hi.delete();
                beats_left = 0;
                mon_en = 1'b1;
            end else if (beats_left == 0) begin
                if (en) push_beats(din);
            end else if (out_ready) begin
                beats_left--;
            end
        end
    end

    task automatic check_one(input bit hi, input logic ir, input logic ov,
                             input logic [1:0] yy, input logic ll, input logic zz);
        int n;
        logic [3:0] exp_beat;
        string tag;
        tag = hi ? "hi" : "lo";
        n = hi ? q_hi.size() : q_lo.size();
        cmp({tag, "_in_ready"}, int'(ir), int'(n == 0));
        cmp({tag, "_out_valid"}, int'(ov), int'(n != 0));
        if (ov && n != 0) begin
            exp_beat = hi ? q_hi[0] : q_lo[0];
            cmp({tag, "_beat{y,last,zero}"}, int'({yy, ll, zz}), int'(exp_beat));
        end else if (!ov) begin
            cmp({tag, "_idle{y,last,zero}"}, int'({yy, ll, zz}), 0);
        end
        if (n != 0 && out_ready) begin
            if (hi) void'(q_hi.pop_front());
            else    void'(q_lo.pop_front());
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check_one(1'b0, lo_in_ready, lo_out_valid, lo_y, lo_last, lo_zero);
                check_one(1'b1, hi_in_ready, hi_out_valid, hi_y, hi_last, hi_zero);
            end
        end
    end

    task automatic cyc(input logic e, input logic [3:0] d, input logic r, input logic s);
        en = e;
        din = d;
        out_ready = r;
        rst = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        // One-hot
        cyc(1'b1, 4'b0100, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 4'd0, 1'b1, 1'b0);
        // Multi-hot, both orders
        cyc(1'b1, 4'b1011, 1'b1, 1'b0);
        repeat (5) cyc(1'b0, 4'd0, 1'b1, 1'b0);
        // Stall with an ignored capture attempt
        cyc(1'b1, 4'b0110, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 4'b1111, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 4'd0, 1'b1, 1'b0);
        // Zero vector
        cyc(1'b1, 4'b0000, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 4'd0, 1'b1, 1'b0);
        // Reset after the first handshake
        cyc(1'b1, 4'b1111, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        cyc(1'b1, 4'b0001, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 4'd0, 1'b1, 1'b0);
        // Random traffic with backpressure and occasional resets
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 59) == 0));
        end
        repeat (10) cyc(1'b0, 4'd0, 1'b1, 1'b0);
        cmp("drain_lo", q_lo.size(), 0);
        cmp("drain_hi", q_hi.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
